// File: rtl/text_term_writer.sv
// PS/2 set-2 scan codes -> ASCII cell writes into a COLS x ROWS text buffer with a hardware cursor.
// Optional TEXT_TERM_CLEAR_ON_RESET_EN: sweep FILL_CHAR over the whole buffer after reset release.
module text_term_writer #(
   parameter int         COLS      = 70,
   parameter int         ROWS      = 30,
   parameter logic [7:0] FILL_CHAR = 8'h20
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  scan_code,
   input  logic        scan_valid,
   output logic        scan_ready,
   output logic        wr_en,
   output logic [11:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic [6:0]  cur_col,
   output logic [4:0]  cur_row,
   output logic [7:0]  key_count,
   output logic        busy
);

   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [6:0] CLR_END  = 7'(COLS);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
`ifdef TEXT_TERM_CLEAR_ON_RESET_EN
   localparam logic [4:0] ROW_END  = 5'(ROWS);
`endif

   localparam logic [7:0] CODE_BRK   = 8'hF0;
   localparam logic [7:0] CODE_EXT   = 8'hE0;
   localparam logic [7:0] CODE_LSH   = 8'h12;
   localparam logic [7:0] CODE_RSH   = 8'h59;
   localparam logic [7:0] CODE_ENTER = 8'h5A;
   localparam logic [7:0] CODE_BKSP  = 8'h66;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      BRK     = 3'd1,
      EXT     = 3'd2,
      CLR     = 3'd3,
      CLR_ALL = 3'd4
   } state_t;

   // {unshifted, shifted} ASCII for a US-layout make code; 16'h0000 when the key is unmapped.
   function automatic logic [15:0] key_pair(input logic [7:0] code);
      logic [15:0] pair;
      case (code)
         8'h1C: pair = {8'h61, 8'h41};
         8'h32: pair = {8'h62, 8'h42};
         8'h21: pair = {8'h63, 8'h43};
         8'h23: pair = {8'h64, 8'h44};
         8'h24: pair = {8'h65, 8'h45};
         8'h2B: pair = {8'h66, 8'h46};
         8'h34: pair = {8'h67, 8'h47};
         8'h33: pair = {8'h68, 8'h48};
         8'h43: pair = {8'h69, 8'h49};
         8'h3B: pair = {8'h6A, 8'h4A};
         8'h42: pair = {8'h6B, 8'h4B};
         8'h4B: pair = {8'h6C, 8'h4C};
         8'h3A: pair = {8'h6D, 8'h4D};
         8'h31: pair = {8'h6E, 8'h4E};
         8'h44: pair = {8'h6F, 8'h4F};
         8'h4D: pair = {8'h70, 8'h50};
         8'h15: pair = {8'h71, 8'h51};
         8'h2D: pair = {8'h72, 8'h52};
         8'h1B: pair = {8'h73, 8'h53};
         8'h2C: pair = {8'h74, 8'h54};
         8'h3C: pair = {8'h75, 8'h55};
         8'h2A: pair = {8'h76, 8'h56};
         8'h1D: pair = {8'h77, 8'h57};
         8'h22: pair = {8'h78, 8'h58};
         8'h35: pair = {8'h79, 8'h59};
         8'h1A: pair = {8'h7A, 8'h5A};
         8'h45: pair = {8'h30, 8'h29};
         8'h16: pair = {8'h31, 8'h21};
         8'h1E: pair = {8'h32, 8'h40};
         8'h26: pair = {8'h33, 8'h23};
         8'h25: pair = {8'h34, 8'h24};
         8'h2E: pair = {8'h35, 8'h25};
         8'h36: pair = {8'h36, 8'h5E};
         8'h3D: pair = {8'h37, 8'h26};
         8'h3E: pair = {8'h38, 8'h2A};
         8'h46: pair = {8'h39, 8'h28};
         8'h29: pair = {8'h20, 8'h20};
         8'h4E: pair = {8'h2D, 8'h5F};
         8'h55: pair = {8'h3D, 8'h2B};
         8'h41: pair = {8'h2C, 8'h3C};
         8'h49: pair = {8'h2E, 8'h3E};
         8'h4A: pair = {8'h2F, 8'h3F};
         8'h4C: pair = {8'h3B, 8'h3A};
         8'h52: pair = {8'h27, 8'h22};
         default: pair = 16'h0000;
      endcase
      return pair;
   endfunction

   function automatic logic [4:0] row_inc(input logic [4:0] r);
      return (r == LAST_ROW) ? 5'd0 : r + 5'd1;
   endfunction

   state_t      state_r, state_s;
   logic        shift_r, shift_s;
   logic [6:0]  col_r, col_s;
   logic [4:0]  row_r, row_s;
   logic [7:0]  count_r, count_s;
   logic [6:0]  clr_col_r, clr_col_s;
`ifdef TEXT_TERM_CLEAR_ON_RESET_EN
   logic [4:0]  clr_row_r, clr_row_s;
`endif
   logic        wr_en_r, wr_en_s;
   logic [11:0] wr_addr_r, wr_addr_s;
   logic [7:0]  wr_data_r, wr_data_s;
   logic        ready_r, ready_s;
   logic        busy_r, busy_s;
   logic        accept_s;
   logic        is_shift_s;
   logic [15:0] pair_s;
   logic [7:0]  char_s;

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
`ifdef TEXT_TERM_CLEAR_ON_RESET_EN
         state_r <= CLR_ALL;
`else
         state_r <= IDLE;
`endif
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state, cursor and write-port decode.
   always_comb begin
      state_s    = state_r;
      shift_s    = shift_r;
      col_s      = col_r;
      row_s      = row_r;
      count_s    = count_r;
      clr_col_s  = clr_col_r;
`ifdef TEXT_TERM_CLEAR_ON_RESET_EN
      clr_row_s  = clr_row_r;
`endif
      wr_en_s    = 1'b0;
      wr_addr_s  = 12'h000;
      wr_data_s  = 8'h00;
      busy_s     = 1'b0;
      accept_s   = scan_valid && ready_r;
      is_shift_s = (scan_code == CODE_LSH) || (scan_code == CODE_RSH);
      pair_s     = key_pair(scan_code);
      char_s     = shift_r ? pair_s[7:0] : pair_s[15:8];

      case (state_r)
         IDLE: begin
            if (!accept_s) begin
               state_s = IDLE;
            end else if (scan_code == CODE_BRK) begin
               state_s = BRK;
            end else if (scan_code == CODE_EXT) begin
               state_s = EXT;
            end else if (is_shift_s) begin
               shift_s = 1'b1;
            end else if (scan_code == CODE_ENTER) begin
               col_s     = 7'd0;
               row_s     = row_inc(row_r);
               clr_col_s = 7'd0;
               state_s   = CLR;
            end else if (scan_code == CODE_BKSP) begin
               if (col_r != 7'd0) begin
                  col_s     = col_r - 7'd1;
                  wr_en_s   = 1'b1;
                  wr_addr_s = {row_r, col_r - 7'd1};
                  wr_data_s = FILL_CHAR;
               end else if (row_r != 5'd0) begin
                  row_s     = row_r - 5'd1;
                  col_s     = LAST_COL;
                  wr_en_s   = 1'b1;
                  wr_addr_s = {row_r - 5'd1, LAST_COL};
                  wr_data_s = FILL_CHAR;
               end else begin
                  col_s = col_r;
               end
            end else if (pair_s != 16'h0000) begin
               wr_en_s   = 1'b1;
               wr_addr_s = {row_r, col_r};
               wr_data_s = char_s;
               count_s   = count_r + 8'd1;
               if (col_r != LAST_COL) begin
                  col_s = col_r + 7'd1;
               end else begin
                  // Wrapping off the last column lands on a fresh row that must be blanked first.
                  col_s     = 7'd0;
                  row_s     = row_inc(row_r);
                  clr_col_s = 7'd0;
                  state_s   = CLR;
               end
            end else begin
               state_s = IDLE;
            end
         end
         BRK: begin
            if (accept_s) begin
               shift_s = is_shift_s ? 1'b0 : shift_r;
               state_s = IDLE;
            end else begin
               state_s = BRK;
            end
         end
         EXT: begin
            if (accept_s) begin
               state_s = (scan_code == CODE_BRK) ? EXT : IDLE;
            end else begin
               state_s = EXT;
            end
         end
         CLR: begin
            if (clr_col_r != CLR_END) begin
               wr_en_s   = 1'b1;
               wr_addr_s = {row_r, clr_col_r};
               wr_data_s = FILL_CHAR;
               busy_s    = 1'b1;
               clr_col_s = clr_col_r + 7'd1;
            end else begin
               state_s = IDLE;
            end
         end
`ifdef TEXT_TERM_CLEAR_ON_RESET_EN
         CLR_ALL: begin
            if (clr_row_r != ROW_END) begin
               wr_en_s   = 1'b1;
               wr_addr_s = {clr_row_r, clr_col_r};
               wr_data_s = FILL_CHAR;
               busy_s    = 1'b1;
               if (clr_col_r == LAST_COL) begin
                  clr_col_s = 7'd0;
                  clr_row_s = clr_row_r + 5'd1;
               end else begin
                  clr_col_s = clr_col_r + 7'd1;
               end
            end else begin
               col_s   = 7'd0;
               row_s   = 5'd0;
               state_s = IDLE;
            end
         end
`endif
         default: begin
            state_s = IDLE;
         end
      endcase

      ready_s = (state_s != CLR) && (state_s != CLR_ALL);
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         shift_r   <= 1'b0;
         col_r     <= 7'd0;
         row_r     <= 5'd0;
         count_r   <= 8'd0;
         clr_col_r <= 7'd0;
`ifdef TEXT_TERM_CLEAR_ON_RESET_EN
         clr_row_r <= 5'd0;
         ready_r   <= 1'b0;
`else
         ready_r   <= 1'b1;
`endif
         wr_en_r   <= 1'b0;
         wr_addr_r <= 12'h000;
         wr_data_r <= 8'h00;
         busy_r    <= 1'b0;
      end else begin
         shift_r   <= shift_s;
         col_r     <= col_s;
         row_r     <= row_s;
         count_r   <= count_s;
         clr_col_r <= clr_col_s;
`ifdef TEXT_TERM_CLEAR_ON_RESET_EN
         clr_row_r <= clr_row_s;
`endif
         ready_r   <= ready_s;
         wr_en_r   <= wr_en_s;
         wr_addr_r <= wr_addr_s;
         wr_data_r <= wr_data_s;
         busy_r    <= busy_s;
      end
   end

   assign scan_ready = ready_r;
   assign wr_en      = wr_en_r;
   assign wr_addr    = wr_addr_r;
   assign wr_data    = wr_data_r;
   assign cur_col    = col_r;
   assign cur_row    = row_r;
   assign key_count  = count_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_text_term_writer.sv
// Bench for text_term_writer: directed scenarios plus random scan-code streams checked
// against a keyboard/screen model built from lookup tables and plain cursor arithmetic.
module tb_text_term_writer;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [7:0]  scan_code = 8'h00;
   logic        scan_valid = 1'b0;
   logic        scan_ready, wr_en, busy;
   logic [11:0] wr_addr;
   logic [7:0]  wr_data, key_count;
   logic [6:0]  cur_col;
   logic [4:0]  cur_row;

   text_term_writer dut (
      .clk(clk), .resetn(resetn), .scan_code(scan_code), .scan_valid(scan_valid),
      .scan_ready(scan_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cur_col(cur_col), .cur_row(cur_row), .key_count(key_count), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed { int c; logic [11:0] a; logic [7:0] d; } wr_t;
   wr_t        got_q[$];
   wr_t        exp_q[$];
   int         cyc = 0, last_acc = 0, low_cnt = 0, busy_cnt = 0, rd_idx = 0;
   int         total = 0, bad = 0;
   logic [7:0] lo_tab[256];
   logic [7:0] hi_tab[256];
   logic [7:0] codes[$];
   int         m_mode, m_shift, m_col, m_row, m_cnt, exp_low, exp_busy;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (scan_valid && scan_ready) last_acc <= cyc;
   end

   always @(negedge clk) begin
      if (wr_en) got_q.push_back('{cyc, wr_addr, wr_data});
      if (!scan_ready) low_cnt <= low_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic build_tables();
      logic [7:0] let_c[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
      logic [7:0] dig_c[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
      logic [7:0] sym_c[8]  = '{8'h29, 8'h4E, 8'h55, 8'h41, 8'h49, 8'h4A, 8'h4C, 8'h52};
      string dsh = ")!@#$%^&*(";
      string slo = " -=,./;'";
      string shi = " _+<>?:\"";
      for (int i = 0; i < 256; i++) begin lo_tab[i] = 8'h00; hi_tab[i] = 8'h00; end
      for (int i = 0; i < 26; i++) begin
         lo_tab[let_c[i]] = 8'h61 + 8'(i); hi_tab[let_c[i]] = 8'h41 + 8'(i); codes.push_back(let_c[i]);
      end
      for (int i = 0; i < 10; i++) begin
         lo_tab[dig_c[i]] = 8'h30 + 8'(i); hi_tab[dig_c[i]] = dsh[i]; codes.push_back(dig_c[i]);
      end
      for (int i = 0; i < 8; i++) begin
         lo_tab[sym_c[i]] = slo[i]; hi_tab[sym_c[i]] = shi[i]; codes.push_back(sym_c[i]);
      end
   endtask

   task automatic exp_wr(input int c, input int r, input int col, input logic [7:0] d);
      exp_q.push_back('{c, 12'(r * 128 + col), d});
   endtask

   task automatic model_clear(input int k);
      for (int c = 0; c < 70; c++) exp_wr(k + 2 + c, m_row, c, 8'h20);
      exp_low  = 71;
      exp_busy = 70;
   endtask

   // Screen/keyboard reference: mode 0 normal, 1 after F0, 2 after E0.
   task automatic model_byte(input logic [7:0] b, input int k);
      exp_low  = 0;
      exp_busy = 0;
      if (m_mode == 1) begin
         if (b == 8'h12 || b == 8'h59) m_shift = 0;
         m_mode = 0;
      end else if (m_mode == 2) begin
         if (b != 8'hF0) m_mode = 0;
      end else if (b == 8'hF0) m_mode = 1;
      else if (b == 8'hE0) m_mode = 2;
      else if (b == 8'h12 || b == 8'h59) m_shift = 1;
      else if (b == 8'h5A) begin
         m_col = 0; m_row = (m_row + 1) % 30; model_clear(k);
      end else if (b == 8'h66) begin
         if (m_col > 0) begin
            m_col--; exp_wr(k + 1, m_row, m_col, 8'h20);
         end else if (m_row > 0) begin
            m_row--; m_col = 69; exp_wr(k + 1, m_row, m_col, 8'h20);
         end
      end else if (lo_tab[b] != 8'h00) begin
         exp_wr(k + 1, m_row, m_col, (m_shift != 0) ? hi_tab[b] : lo_tab[b]);
         m_cnt = (m_cnt + 1) % 256;
         if (m_col < 69) m_col++;
         else begin
            m_col = 0; m_row = (m_row + 1) % 30; model_clear(k);
         end
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n, l0, b0, k, ngot;
      wr_t g, e;
      @(negedge clk);
      n = 0;
      while (!scan_ready && n < 300) begin @(negedge clk); n++; end
      chk("ready_wait", 32'(scan_ready), 32'd1);
      l0 = low_cnt; b0 = busy_cnt;
      scan_code = b; scan_valid = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0;
      k = last_acc;
      model_byte(b, k);
      chk("cur_col", 32'(cur_col), m_col);
      chk("cur_row", 32'(cur_row), m_row);
      @(negedge clk);
      n = 0;
      while (!scan_ready && n < 300) begin @(negedge clk); n++; end
      chk("settle", 32'(scan_ready), 32'd1);
      ngot = got_q.size() - rd_idx;
      chk("wr_count", ngot, exp_q.size());
      for (int i = 0; i < ngot && i < exp_q.size(); i++) begin
         g = got_q[rd_idx + i];
         e = exp_q[i];
         chk("wr_entry", {8'(g.c - k), g.a, g.d}, {8'(e.c - k), e.a, e.d});
      end
      chk("ready_low", low_cnt - l0, exp_low);
      chk("busy_cyc", busy_cnt - b0, exp_busy);
      chk("key_count", 32'(key_count), m_cnt);
      rd_idx = got_q.size();
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("rst_ready", 32'(scan_ready), 32'd1);
      chk("rst_outs", {wr_en, wr_addr, wr_data, cur_col, cur_row, busy}, 32'd0);
      chk("rst_count", 32'(key_count), 32'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      m_mode = 0; m_shift = 0; m_col = 0; m_row = 0; m_cnt = 0;
      exp_q.delete();
      rd_idx = got_q.size();
   endtask

   initial begin
      logic [7:0] b;
      int r;
      build_tables();
      repeat (2) @(negedge clk);
      do_reset();

      send(8'h1C); send(8'hF0); send(8'h1C);
      chk("tp1_col", 32'(cur_col), 32'd1);
      chk("tp1_cnt", 32'(key_count), 32'd1);

      do_reset();
      send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
      chk("tp2_col", 32'(cur_col), 32'd2);

      do_reset();
      repeat (70) send(8'h32);
      chk("tp3_pos", {cur_row, cur_col}, {5'd1, 7'd0});
      send(8'h66);
      chk("tp4_pos", {cur_row, cur_col}, {5'd0, 7'd69});
      repeat (70) send(8'h66);
      chk("tp4_home", {cur_row, cur_col}, 12'd0);

      repeat (29) send(8'h5A);
      chk("tp5_row29", 32'(cur_row), 32'd29);
      send(8'h5A);
      chk("tp5_row0", 32'(cur_row), 32'd0);
      send(8'hE0); send(8'h75); send(8'h1C);

      // Reset in the middle of a row clear.
      do_reset();
      @(negedge clk);
      scan_code = 8'h5A; scan_valid = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("midclr_busy", 32'(busy), 32'd1);
      do_reset();
      send(8'h1C);

      repeat (600) begin
         r = $urandom_range(0, 99);
         if (r < 50) b = codes[$urandom_range(0, codes.size() - 1)];
         else if (r < 58) b = 8'hF0;
         else if (r < 62) b = 8'hE0;
         else if (r < 67) b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
         else if (r < 77) b = 8'h66;
         else if (r < 85) b = 8'h5A;
         else b = 8'($urandom_range(0, 255));
         send(b);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/text_term_writer.md
Name: text_term_writer

Overview:
- Text-terminal writer sitting directly upstream of the text-mode character buffer (70x30 ASCII cells, 9x16 font).
- Consumes PS/2 set-2 scan-code bytes from the keyboard receiver, tracks make/break/extended prefixes and Shift, and translates keys to ASCII.
- Writes ASCII into the buffer at a hardware cursor; handles Enter, Backspace, line wrap and row clearing.
- Exports the cursor position and a keystroke count for the seven-segment display.

Parameters:
- COLS, 70, characters per row; max column index COLS-1.
- ROWS, 30, rows on screen; max row index ROWS-1.
- FILL_CHAR, 8'h20, byte written when clearing or erasing a cell.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- scan_code  input  8  scan-code byte from the keyboard receiver.
- scan_valid  input  1  scan_code holds an unconsumed byte.
- scan_ready  output  1  the block can accept a byte; a byte transfers when scan_valid && scan_ready on a clk rising edge.
- wr_en  output  1  buffer write strobe, one cycle per cell.
- wr_addr  output  12  buffer address {row[4:0], col[6:0]}.
- wr_data  output  8  ASCII byte to write.
- cur_col  output  7  cursor column, 0..COLS-1.
- cur_row  output  5  cursor row, 0..ROWS-1.
- key_count  output  8  printable-key count; wraps 255->0.
- busy  output  1  high while a row clear is in progress.

Behaviour:
- Reset values (async, resetn=0): all outputs 0 except scan_ready=1; state=IDLE; shift=0.
- States:
  - IDLE, BRK (after F0), EXT (after E0): scan_ready=1.
  - CLR: scan_ready=0, busy=1.
- Transitions on an accepted byte:
  - IDLE: F0 -> BRK; E0 -> EXT; 12/59 -> shift=1; else make-code handling.
  - BRK: byte 12/59 -> shift=0; any byte -> IDLE; no write.
  - EXT: F0 -> stay in EXT; any other byte -> IDLE; no write. Extended keys are ignored.
- Make-code handling:
  - Translation: US layout covering A-Z, 0-9, space, minus, equals, comma, period, slash, semicolon, quote.
  - Shift=1 gives uppercase letters and US shifted symbols; e.g. 1C->'a'/'A', 16->'1'/'!', 29->' ' (either shift state).
  - Unmapped codes are consumed, with no write and no cursor move.
- Printable key:
  - Write the char at (row,col); key_count+1.
  - If col<COLS-1: col+1.
  - Else: col=0, row=(row+1) mod ROWS, enter CLR.
- Enter (5A): col=0, row=(row+1) mod ROWS, enter CLR; no write; key_count unchanged.
- Backspace (66):
  - col>0: col-1, write FILL_CHAR at the new position.
  - col=0, row>0: row-1, col=COLS-1, write FILL_CHAR there.
  - (0,0): no write, no move.
- Latency: wr_en/wr_addr/wr_data are registered and valid the cycle after the accepting edge; cur_col/cur_row update on the same edge as the write.
- CLR:
  - Writes FILL_CHAR to cols 0..COLS-1 of the new cur_row, one per cycle (COLS cycles), starting the cycle after entry.
  - Returns to IDLE after the last write; scan_ready rises the cycle after the last wr_en.
- Typematic repeats of make codes each produce a character.
- Row wrap 29->0 clears row 0. There is no scroll.
- resetn low mid-CLR aborts the clear immediately; partially cleared cells remain as-is.
- scan_valid low: no state change. Bytes are never dropped while scan_ready=1.

Optional Feature:
- Macro: TEXT_TERM_CLEAR_ON_RESET_EN.
- Defined:
  - After reset release, a CLR_ALL sweep writes FILL_CHAR to every cell, row 0..ROWS-1 and col 0..COLS-1 (2100 writes, row-major, one per cycle).
  - busy=1 and scan_ready=0 during the sweep; then IDLE at cursor (0,0).
- Not defined: buffer contents are untouched after reset; the block is IDLE with scan_ready=1 immediately.

Test Plan:
- Reset then bytes 1C, F0, 1C -> one write addr 12'h000 data 8'h61; cursor (1,0); key_count=1; the break pair produces no write.
- 12, 1C, F0, 12, 1C -> writes 'A' at col 0 then 'a' at col 1; shift released correctly.
- 70 presses of 32 -> last 'b' at col 69; cursor (0,1); busy high 70 cycles with writes FILL_CHAR to addr 12'h080..12'h0C5; scan_ready low throughout.
- Cursor at (0,1), then 66 -> write 8'h20 at addr 12'h045; cursor (69,0). Repeat 66 at (0,0) -> no wr_en.
- Enter at row 29 -> cursor (0,0) and row 0 cleared. Then E0, 75 (up arrow) -> no write, state back to IDLE.
- Assert resetn mid-CLR -> all outputs return to reset values immediately; scan_ready=1 once out of reset (macro undefined).
